// File: rtl/idct_lane_round_sat_pkg.sv
// Purpose: shared definitions for the IDCT post-scaling stream stage.
//   - state_e    : stage FSM encoding (RUN=0, DONE=1)
//   - FIFO_DEPTH : depth of the output skid FIFO
//   - sat_min / sat_max : clamp bounds for an OW-bit output, signed or unsigned
// Ports: none (package).
package idct_stream_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam int FIFO_DEPTH = 2;

    function automatic int sat_min(input int ow, input bit signed_out);
        return signed_out ? -(1 << (ow - 1)) : 0;
    endfunction

    function automatic int sat_max(input int ow, input bit signed_out);
        return signed_out ? (1 << (ow - 1)) - 1 : (1 << ow) - 1;
    endfunction

endpackage

// File: rtl/idct_lane_round_sat_if.sv
// Purpose: stream bundle between the IDCT column pass, this stage and its consumer.
// Handshake: on every lane a token moves when v=1 and b=0 at the same rising
//   clock edge; b is back-pressure (1 = not ready), data and e are only
//   meaningful while v=1.
// Signals:
//   in_d  [LANES*IW]  input samples, lane i at [i*IW +: IW]
//   in_e  [LANES]     input end-of-stream flags
//   in_v  [LANES]     input valid
//   in_b  [LANES]     back-pressure to the producer
//   out_d [LANES*OW]  output samples, lane i at [i*OW +: OW]
//   out_e [LANES]     output end-of-stream flags
//   out_v [LANES]     output valid
//   out_b [LANES]     back-pressure from the consumer
// Modports: master = producer/consumer side, slave = the stage itself.
interface idct_lane_round_sat_if #(
    parameter int LANES = 8,
    parameter int IW    = 16,
    parameter int OW    = 9
);
    logic [LANES*IW-1:0] in_d;
    logic [LANES-1:0]    in_e;
    logic [LANES-1:0]    in_v;
    logic [LANES-1:0]    in_b;
    logic [LANES*OW-1:0] out_d;
    logic [LANES-1:0]    out_e;
    logic [LANES-1:0]    out_v;
    logic [LANES-1:0]    out_b;

    modport master (
        output in_d, in_e, in_v, out_b,
        input  in_b, out_d, out_e, out_v
    );

    modport slave (
        input  in_d, in_e, in_v, out_b,
        output in_b, out_d, out_e, out_v
    );
endinterface

// File: rtl/idct_lane_round_sat_lane.sv
// Purpose: one combinational lane: round-half-up, arithmetic right shift,
//   constant offset, then clamp to OW bits (signed or unsigned).
// Ports:
//   x  in  IW  signed IDCT sample
//   y  out OW  scaled, saturated sample
module lane_round_sat
    import idct_stream_pkg::*;
#(
    parameter int IW         = 16,
    parameter int OW         = 9,
    parameter int SHIFT      = 3,
    parameter int OFFSET     = 0,
    parameter int SIGNED_OUT = 1
) (
    input  logic signed [IW-1:0] x,
    output logic        [OW-1:0] y
);
    // Two guard bits: one for the rounding carry, one for the offset add.
    localparam int WW     = IW + 2;
    localparam int BIAS_I = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;

    localparam logic signed [WW-1:0] BIAS = WW'(BIAS_I);
    localparam logic signed [WW-1:0] OFFS = WW'(OFFSET);
    localparam logic signed [WW-1:0] LO   = WW'(sat_min(OW, SIGNED_OUT != 0));
    localparam logic signed [WW-1:0] HI   = WW'(sat_max(OW, SIGNED_OUT != 0));

    logic signed [WW-1:0] xe;
    logic signed [WW-1:0] shf;
    logic signed [WW-1:0] res;

    assign xe  = {{2{x[IW-1]}}, x};
    assign shf = (xe + BIAS) >>> SHIFT;
    assign res = shf + OFFS;

    always_comb begin
        y = res[OW-1:0];
        if (res < LO) begin
            y = LO[OW-1:0];
        end else if (res > HI) begin
            y = HI[OW-1:0];
        end
    end
endmodule

// File: rtl/idct_lane_round_sat.sv
// Purpose: N-lane lock-step round/shift/offset/saturate stage with EOS
//   propagation, EOS-mismatch detection and a 2-entry output skid FIFO.
// Ports:
//   clock    in   sole clock, rising edge
//   reset    in   asynchronous, active-low
//   s        slave modport of idct_lane_round_sat_if (input and output streams)
//   done     out  FSM is in DONE
//   err      out  sticky EOS-mismatch flag
//   state_o  out  raw FSM state, for observation
module idct_lane_round_sat
    import idct_stream_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int IW         = 16,
    parameter int OW         = 9,
    parameter int SHIFT      = 3,
    parameter int OFFSET     = 0,
    parameter int SIGNED_OUT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    idct_lane_round_sat_if.slave  s,
    output logic                  done,
    output logic                  err,
    output state_e                state_o
);
    // FIFO entry layout: {e[LANES-1:0], d[LANES*OW-1:0]}
    localparam int DW = LANES * OW;
    localparam int EW = LANES * (OW + 1);

    state_e          state_q, state_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      cnt_q;
    logic            err_q;

    logic [DW-1:0]   lane_y;
    logic [EW-1:0]   push_entry;
    logic [EW-1:0]   head;
    logic            fire;
    logic            eos_all;
    logic            data_tok;
    logic            push;
    logic            pop;
    logic            mismatch;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_round_sat #(
            .IW         (IW),
            .OW         (OW),
            .SHIFT      (SHIFT),
            .OFFSET     (OFFSET),
            .SIGNED_OUT (SIGNED_OUT)
        ) u_lane (
            .x (s.in_d[g*IW +: IW]),
            .y (lane_y[g*OW +: OW])
        );
    end

    // All lanes must be valid together; a partial valid never consumes.
    assign fire     = (state_q == ST_RUN) && (&s.in_v) && (cnt_q < 2'(FIFO_DEPTH));
    assign eos_all  = &s.in_e;
    assign data_tok = ~|s.in_e;
    assign push     = fire && (eos_all || data_tok);
    assign mismatch = fire && !eos_all && !data_tok;
    // A single back-pressured lane holds the whole entry.
    assign pop      = (cnt_q != 2'd0) && !(|s.out_b);

    assign push_entry = eos_all ? {{LANES{1'b1}}, {DW{1'b0}}}
                                : {{LANES{1'b0}}, lane_y};

    always_comb begin
        state_d = state_q;
        if (fire && !data_tok) begin
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            if (mismatch) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign s.in_b  = {LANES{~fire}};
    assign s.out_v = {LANES{cnt_q != 2'd0}};
    assign s.out_d = (cnt_q != 2'd0) ? head[DW-1:0] : '0;
    assign s.out_e = (cnt_q != 2'd0) ? head[EW-1:DW] : '0;
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_idct_lane_round_sat.sv
// Bench for idct_lane_round_sat: a default 8-lane instance plus a 3-lane
// unsigned, level-shifted instance. Expected entries come from an integer
// model and are queued when a token is accepted, then popped at output.
module tb_idct_lane_round_sat;
    import idct_stream_pkg::*;

    localparam int LANES = 8;
    localparam int IW    = 16;
    localparam int OW    = 9;
    localparam int SHIFT = 3;
    localparam int EW    = LANES * (OW + 1);
    localparam int L2    = 3;
    localparam int OW2   = 8;
    localparam int OFF2  = 128;
    localparam int EW2   = L2 * (OW2 + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    idct_lane_round_sat_if #(.LANES(LANES), .IW(IW), .OW(OW))  if1 ();
    idct_lane_round_sat_if #(.LANES(L2),    .IW(IW), .OW(OW2)) if2 ();

    logic   done1, err1, done2, err2;
    state_e st1, st2;

    idct_lane_round_sat #(
        .LANES(LANES), .IW(IW), .OW(OW), .SHIFT(SHIFT), .OFFSET(0), .SIGNED_OUT(1)
    ) u_dut (
        .clock(clk), .reset(rst_n), .s(if1), .done(done1), .err(err1), .state_o(st1)
    );

    idct_lane_round_sat #(
        .LANES(L2), .IW(IW), .OW(OW2), .SHIFT(SHIFT), .OFFSET(OFF2), .SIGNED_OUT(0)
    ) u_dut2 (
        .clock(clk), .reset(rst_n), .s(if2), .done(done2), .err(err2), .state_o(st2)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [EW-1:0]  exp_q[$];
    logic [EW2-1:0] exp2_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model(input int x, input int off, input int ow, input bit sgn);
        int y, lo, hi;
        y  = ((x + (1 << (SHIFT - 1))) >>> SHIFT) + off;
        lo = sgn ? -(1 << (ow - 1)) : 0;
        hi = sgn ? (1 << (ow - 1)) - 1 : (1 << ow) - 1;
        if (y < lo) y = lo;
        if (y > hi) y = hi;
        return y;
    endfunction

    function automatic logic [EW-1:0] exp_entry(input logic [LANES*IW-1:0] d,
                                                input logic [LANES-1:0] e);
        logic [EW-1:0] r;
        int y;
        r = '0;
        if (e == '1) begin
            r[EW-1 -: LANES] = '1;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                y = model(int'($signed(d[i*IW +: IW])), 0, OW, 1'b1);
                r[i*OW +: OW] = y[OW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [LANES*IW-1:0] pack8(input int v[8]);
        logic [LANES*IW-1:0] r;
        int t;
        for (int i = 0; i < LANES; i++) begin
            t = v[i];
            r[i*IW +: IW] = t[IW-1:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && if1.out_v[0] && (if1.out_b == '0)) begin
            pops++;
            check("sb1_nonempty", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                check("sb1_entry", 128'({if1.out_e, if1.out_d}), 128'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if2.out_v[0] && (if2.out_b == '0)) begin
            check("sb2_nonempty", 128'(exp2_q.size() != 0), 128'(1));
            if (exp2_q.size() != 0) begin
                check("sb2_entry", 128'({if2.out_e, if2.out_d}), 128'(exp2_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic send(input logic [LANES*IW-1:0] d, input logic [LANES-1:0] e);
        bit ok;
        ok = 1'b0;
        if1.in_d = d;
        if1.in_e = e;
        if1.in_v = '1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (if1.in_b == '0) begin
                ok = 1'b1;
                if (e == '0 || e == '1) exp_q.push_back(exp_entry(d, e));
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if1.in_v = '0;
        check("send_accept", 128'(ok), 128'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    int v[8];
    int p0;
    logic [L2*IW-1:0]  d2;
    logic [EW2-1:0]    e2;
    int                x2[3];
    int                y2;

    initial begin
        if1.in_d = '0; if1.in_e = '0; if1.in_v = '0; if1.out_b = '0;
        if2.in_d = '0; if2.in_e = '0; if2.in_v = '0; if2.out_b = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_v", 128'(if1.out_v), 128'(0));
        check("rst_in_b",  128'(if1.in_b),  128'(8'hFF));
        check("rst_out_d", 128'(if1.out_d), 128'(0));
        check("rst_out_e", 128'(if1.out_e), 128'(0));
        check("rst_done",  128'(done1),     128'(0));
        check("rst_err",   128'(err1),      128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // unsigned level-shifted instance
        x2 = '{0, 1200, -2000};
        e2 = '0;
        for (int i = 0; i < L2; i++) begin
            d2[i*IW +: IW] = x2[i][IW-1:0];
            y2 = model(x2[i], OFF2, OW2, 1'b0);
            e2[i*OW2 +: OW2] = y2[OW2-1:0];
        end
        if2.in_d = d2;
        if2.in_v = '1;
        @(negedge clk);
        check("t2_accept", 128'(if2.in_b), 128'(0));
        exp2_q.push_back(e2);
        @(posedge clk);
        #1;
        if2.in_v = '0;
        check("t2_out_v", 128'(if2.out_v), 128'(3'b111));
        @(posedge clk);
        #1;
        check("t2_drained", 128'(exp2_q.size()), 128'(0));

        // main function, directed pattern then random patterns back to back
        v = '{100, -100, 4000, -4000, 0, 4, -5, 255};
        send(pack8(v), '0);
        check("t1_latency_v", 128'(if1.out_v), 128'(8'hFF));
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < LANES; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
            send(pack8(v), '0);
        end
        v = '{32767, -32768, 2043, 2044, -2052, -2053, 3, -4};
        send(pack8(v), '0);
        drain();

        // backpressure: two entries fill the FIFO, the third waits
        if1.out_b = '1;
        v = '{1, 2, 3, 4, 5, 6, 7, 8};
        send(pack8(v), '0);
        v = '{-8, -16, -24, -32, -40, -48, -56, -64};
        send(pack8(v), '0);
        v = '{800, 900, 1000, 1100, 1200, 1300, 1400, 1500};
        fork
            send(pack8(v), '0);
            begin
                repeat (2) begin
                    @(negedge clk);
                    check("t3_full_in_b",  128'(if1.in_b),  128'(8'hFF));
                    check("t3_full_out_v", 128'(if1.out_v), 128'(8'hFF));
                end
                @(posedge clk);
                #1;
                p0 = pops;
                if1.out_b = '0;
                repeat (3) @(posedge clk);
                check("t3_rate", 128'(pops - p0), 128'(3));
            end
        join
        drain();

        // partial valid never consumes
        p0 = pops;
        v = '{10, 20, 30, 40, 50, 60, 70, 80};
        if1.in_d = pack8(v);
        if1.in_e = '0;
        if1.in_v = 8'h7F;
        repeat (5) begin
            @(negedge clk);
            check("t4_in_b",  128'(if1.in_b),  128'(8'hFF));
            check("t4_out_v", 128'(if1.out_v), 128'(0));
            @(posedge clk);
            #1;
        end
        send(pack8(v), '0);
        drain();
        check("t4_single", 128'(pops - p0), 128'(1));

        // EOS after two data tokens
        v = '{-300, 300, 17, -17, 1023, -1023, 9, -9};
        send(pack8(v), '0);
        v = '{5, 6, 7, 8, 9, 10, 11, 12};
        send(pack8(v), '0);
        check("t5_done_before", 128'(done1), 128'(0));
        send('0, '1);
        check("t5_done", 128'(done1), 128'(1));
        if1.in_v = '1;
        @(negedge clk);
        check("t5_ignored_in_b", 128'(if1.in_b), 128'(8'hFF));
        @(posedge clk);
        #1;
        if1.in_v = '0;
        drain();
        check("t5_err", 128'(err1), 128'(0));

        // EOS mismatch
        pulse_reset();
        check("t6_rst_done", 128'(done1), 128'(0));
        send(pack8(v), 8'h01);
        check("t6_err",   128'(err1),      128'(1));
        check("t6_done",  128'(done1),     128'(1));
        @(posedge clk);
        #1;
        check("t6_no_out", 128'(if1.out_v), 128'(0));

        // reset with a full FIFO
        pulse_reset();
        check("t6_err_clr", 128'(err1), 128'(0));
        if1.out_b = '1;
        send(pack8(v), '0);
        send(pack8(v), '0);
        check("t6_full", 128'(if1.out_v), 128'(8'hFF));
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_async_out_v", 128'(if1.out_v), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if1.out_b = '0;
        check("t6_post_err",  128'(err1),      128'(0));
        check("t6_post_in_b", 128'(if1.in_b),  128'(8'hFF));
        check("t6_post_v",    128'(if1.out_v), 128'(0));

        // normal operation after reset
        v = '{-1, 1, -7, 7, 60, -60, 2047, -2049};
        send(pack8(v), '0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
